// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared constants and helpers for the Fibonacci LFSR family.
//   - Legal width range and the two commonly used maximal-length tap masks.
//   - lfsr_max_taps(): recommended maximal-length feedback mask for 3..32 bits.
//     Bit k set means state bit k feeds the XOR; bit WIDTH-1 is always set.
//   - lfsr_taps_ok(): true when the mask includes the top state bit, which is
//     what keeps a non-zero state from ever shifting into all-zero.
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_MIN_WIDTH = 3;
  localparam int LFSR_MAX_WIDTH = 32;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  function automatic logic [31:0] lfsr_max_taps(input int width);
    logic [31:0] taps;
    taps = 32'h0;
    case (width)
      3:  taps = 32'h0000_0006;
      4:  taps = 32'h0000_000C;
      5:  taps = 32'h0000_0014;
      6:  taps = 32'h0000_0030;
      7:  taps = 32'h0000_0060;
      8:  taps = 32'h0000_00B8;
      9:  taps = 32'h0000_0110;
      10: taps = 32'h0000_0240;
      11: taps = 32'h0000_0500;
      12: taps = 32'h0000_0E08;
      13: taps = 32'h0000_1C80;
      14: taps = 32'h0000_3802;
      15: taps = 32'h0000_6000;
      16: taps = 32'h0000_B400;
      17: taps = 32'h0001_2000;
      18: taps = 32'h0002_0400;
      19: taps = 32'h0007_2000;
      20: taps = 32'h0009_0000;
      21: taps = 32'h0014_0000;
      22: taps = 32'h0030_0000;
      23: taps = 32'h0042_0000;
      24: taps = 32'h00E1_0000;
      25: taps = 32'h0120_0000;
      26: taps = 32'h0200_0023;
      27: taps = 32'h0400_0013;
      28: taps = 32'h0900_0000;
      29: taps = 32'h1400_0000;
      30: taps = 32'h2000_0029;
      31: taps = 32'h4800_0000;
      32: taps = 32'h8020_0003;
      default: taps = 32'h0;
    endcase
    return taps;
  endfunction

  function automatic bit lfsr_taps_ok(input int width, input logic [31:0] taps);
    if (width < LFSR_MIN_WIDTH || width > LFSR_MAX_WIDTH) return 1'b0;
    return taps[width-1] == 1'b1;
  endfunction

endpackage

// File: rtl/lfsr_shift1.sv
// -----------------------------------------------------------------------------
// lfsr_shift1
// One combinational Fibonacci LFSR shift. The state moves toward the MSB and
// the XOR of the tapped bits enters bit 0.
// Ports:
//   state : WIDTH-bit current state
//   next  : WIDTH-bit state after one shift
// -----------------------------------------------------------------------------
module lfsr_shift1 #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  logic fb;

  assign fb   = ^(state & TAPS);
  assign next = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_fib.sv
// -----------------------------------------------------------------------------
// lfsr_fib
// Parametrised Fibonacci LFSR advancing STEP shifts per enabled cycle, with
// runtime seed load, zero-seed lock-up protection and a wrap strobe.
// Per-cycle priority: RESET > LOAD > CE > hold.
// Ports:
//   CLK    : clock, all state changes on the rising edge
//   RESET  : synchronous active-high reset, state returns to SEED
//   CE     : advance enable
//   LOAD   : load SEED_I this cycle (CE ignored)
//   SEED_I : runtime seed; zero is rejected and SEED is loaded instead
//   O      : registered current state
//   WRAP   : one-cycle strobe, an advance has just landed on SEED
//   LOCKUP : one-cycle strobe, a zero seed was rejected
// WRAP and LOCKUP are registered on the same edge as O, so they describe the
// value O currently shows.
// -----------------------------------------------------------------------------
module lfsr_fib
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               STEP  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] SEED_I,
  output logic [WIDTH-1:0] O,
  output logic             WRAP,
  output logic             LOCKUP
);

  // Elaboration-time parameter checks.
  if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("lfsr_fib: WIDTH must be in 3..32");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_fib: STEP must be in 1..WIDTH");
  end
  if (!lfsr_taps_ok(WIDTH, 32'(TAPS))) begin : g_bad_taps
    $error("lfsr_fib: TAPS must include bit WIDTH-1");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_fib: SEED must be non-zero");
  end

  logic [WIDTH-1:0] state_q;
  logic             wrap_q;
  logic             lockup_q;
  logic [WIDTH-1:0] chain [0:STEP];
  logic [WIDTH-1:0] advanced;

  // STEP single shifts chained back to back; chain[STEP] is the advanced state.
  assign chain[0] = state_q;
  for (genvar i = 0; i < STEP; i++) begin : g_step
    lfsr_shift1 #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_shift (
      .state (chain[i]),
      .next  (chain[i+1])
    );
  end
  assign advanced = chain[STEP];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= SEED;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else if (LOAD) begin
      wrap_q <= 1'b0;
      if (SEED_I != '0) begin
        state_q  <= SEED_I;
        lockup_q <= 1'b0;
      end else begin
        // All-zero would be a dead state; fall back to SEED and flag it.
        state_q  <= SEED;
        lockup_q <= 1'b1;
      end
    end else if (CE) begin
      state_q  <= advanced;
      wrap_q   <= (advanced == SEED);
      lockup_q <= 1'b0;
    end else begin
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end
  end

  assign O      = state_q;
  assign WRAP   = wrap_q;
  assign LOCKUP = lockup_q;

endmodule

// File: tb/tb_lfsr_fib.sv
// -----------------------------------------------------------------------------
// tb_lfsr_fib
// Table of directed vectors against the default 8-bit LFSR, followed by
// hand-written long sequences for wrap timing (STEP=1, STEP=2) and a 16-bit
// instance. All three instances share the control inputs.
// -----------------------------------------------------------------------------
module tb_lfsr_fib;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        ce;
  logic [7:0]  seed8;
  logic [15:0] seed16;

  always #5 clk = ~clk;

  logic [7:0]  o0, o1;
  logic [15:0] o2;
  logic        wrap0, wrap1, wrap2;
  logic        lock0, lock1, lock2;

  lfsr_fib u_dut0 (
    .CLK(clk), .RESET(rst), .CE(ce), .LOAD(load), .SEED_I(seed8),
    .O(o0), .WRAP(wrap0), .LOCKUP(lock0)
  );

  lfsr_fib #(.STEP(2)) u_dut1 (
    .CLK(clk), .RESET(rst), .CE(ce), .LOAD(load), .SEED_I(seed8),
    .O(o1), .WRAP(wrap1), .LOCKUP(lock1)
  );

  lfsr_fib #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .STEP(1)) u_dut2 (
    .CLK(clk), .RESET(rst), .CE(ce), .LOAD(load), .SEED_I(seed16),
    .O(o2), .WRAP(wrap2), .LOCKUP(lock2)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled there
  // too, i.e. well away from the next active edge.
  task automatic apply(input logic r, input logic l, input logic c, input logic [7:0] s);
    rst   = r;
    load  = l;
    ce    = c;
    seed8 = s;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       load;
    logic       ce;
    logic [7:0] seed;
    logic [7:0] exp_o;
    logic       exp_wrap;
    logic       exp_lock;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  initial begin
    rst = 1'b0; load = 1'b0; ce = 1'b0; seed8 = 8'h00; seed16 = 16'h0000;

    //           rst   load  ce    seed   o      wrap  lock
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0}; // reset beats CE
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h55, 8'h01, 1'b0, 1'b0}; // reset beats LOAD
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h08, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h23, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h23, 1'b0, 1'b0}; // idle holds
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1}; // zero seed rejected
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0}; // lockup one cycle
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0}; // load beats CE
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1}; // back-to-back loads
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h4A, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h95, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0}; // mid-sequence reset
    vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0}; // CE 1,0,0,1
    vecs[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0}; // loading SEED is no wrap
    vecs[23] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0};

    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].rst, vecs[i].load, vecs[i].ce, vecs[i].seed);
      check($sformatf("vec%0d_o", i),      32'(o0),    32'(vecs[i].exp_o));
      check($sformatf("vec%0d_wrap", i),   32'(wrap0), 32'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_lockup", i), 32'(lock0), 32'(vecs[i].exp_lock));
    end

    // ---- STEP=1: WRAP exactly at enabled cycles 255 and 510 ----
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    check("s1_reset_o", 32'(o0), 32'h01);
    for (int i = 1; i <= 510; i++) begin
      apply(1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("s1_wrap_c%0d", i), 32'(wrap0), 32'((i == 255) || (i == 510)));
      if (o0 == 8'h00) check($sformatf("s1_nonzero_c%0d", i), 32'(o0), 32'h1);
      if (i == 255 || i == 510) check($sformatf("s1_seed_at_c%0d", i), 32'(o0), 32'h01);
    end
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    check("s1_wrap_drops", 32'(wrap0), 32'h0);

    // ---- STEP=2: 04, 11, 47, ... WRAP first at enabled cycle 255 ----
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    check("s2_reset_o", 32'(o1), 32'h01);
    for (int i = 1; i <= 255; i++) begin
      apply(1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("s2_wrap_c%0d", i), 32'(wrap1), 32'(i == 255));
      if (i == 1)   check("s2_c1_o", 32'(o1), 32'h04);
      if (i == 2)   check("s2_c2_o", 32'(o1), 32'h11);
      if (i == 3)   check("s2_c3_o", 32'(o1), 32'h47);
      if (i == 255) check("s2_c255_o", 32'(o1), 32'h01);
    end

    // ---- 16-bit instance: non-zero states, WRAP first at cycle 65535 ----
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    check("w16_reset_o", 32'(o2), 32'hACE1);
    check("w16_reset_wrap", 32'(wrap2), 32'h0);
    check("w16_reset_lockup", 32'(lock2), 32'h0);
    for (int i = 1; i <= 65535; i++) begin
      apply(1'b0, 1'b0, 1'b1, 8'h00);
      if (i == 1) check("w16_c1_o", 32'(o2), 32'h59C3);
      if (i <= 16) check($sformatf("w16_nonzero_c%0d", i), 32'(o2 != 16'h0), 32'h1);
      if (wrap2 !== (i == 65535)) check($sformatf("w16_wrap_c%0d", i), 32'(wrap2), 32'(i == 65535));
    end
    check("w16_wrap_c65535", 32'(wrap2), 32'h1);
    check("w16_c65535_o", 32'(o2), 32'hACE1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
